// File: rtl/fft256_pkg.sv
// -----------------------------------------------------------------------------
// fft256_pkg
// Shared definitions for the 256-point FFT frame scheduler:
//   FRAME_LEN / FRAME_LOG2 : samples per FFT frame and its log2
//   sched_state_t          : input-side scheduler states
// No ports (package).
// -----------------------------------------------------------------------------
package fft256_pkg;

    localparam int FRAME_LEN  = 256;
    localparam int FRAME_LOG2 = 8;

    // IDLE  : waiting for a full frame to be buffered
    // BURST : streaming one frame into the pipeline, one sample per cycle
    // GAP   : enforced quiet time on di_en between bursts
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } sched_state_t;

    // Index of the final sample in a frame, at frame-counter width.
    function automatic logic [FRAME_LOG2-1:0] frame_last_idx();
        return FRAME_LOG2'(FRAME_LEN - 1);
    endfunction

endpackage

// File: rtl/fft_sync_fifo.sv
// -----------------------------------------------------------------------------
// fft_sync_fifo
// Single-clock FIFO holding packed complex samples ahead of the FFT pipeline.
// The head entry is presented combinationally on rd_data; a pop advances it.
// Writes while full and reads while empty are ignored. A synchronous clear
// empties the FIFO and takes priority over a same-cycle write or read.
//
// Ports:
//   clock    in  : rising-edge clock
//   reset    in  : asynchronous active-high reset (empties the FIFO)
//   clear    in  : synchronous clear, FIFO is empty after this edge
//   wr_en    in  : push wr_data
//   wr_data  in  : WIDTH-bit entry
//   rd_en    in  : pop the head entry
//   rd_data  out : current head entry
//   level    out : registered occupancy, 0..DEPTH
//   full     out : level == DEPTH
//   empty    out : level == 0
// -----------------------------------------------------------------------------
module fft_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers
    // have been cleared.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/fft256_frame_sched.sv
// -----------------------------------------------------------------------------
// fft256_frame_sched
// Frame scheduler for a 256-point radix-2^2 SDF FFT pipeline.
// Input side : buffers upstream samples and releases each frame as a single
//              gap-free 256-cycle fft_di_en burst, since the pipeline stages
//              cannot stall mid-frame. Bursts are separated by >= GAP idle
//              cycles.
// Output side: splits the pipeline's fft_do_en stream into numbered frames,
//              marks first/last samples and flags fragmented frames.
//
// Ports:
//   clock, reset              : clock and asynchronous active-high reset
//   in_valid/in_ready         : upstream handshake, sample = in_re/in_im
//   flush                     : pulse, discard buffered unreleased samples
//   fft_di_en/re/im           : registered pipeline input
//   fft_do_en/re/im           : pipeline output
//   out_valid/re/im           : registered framed output (no backpressure)
//   out_first/out_last        : sample 0 / 255 of the current frame
//   out_frame                 : frame number, wraps at 256
//   busy                      : FIFO non-empty or scheduler not idle
//   err_frag                  : sticky, fft_do_en dropped mid-frame
// -----------------------------------------------------------------------------
module fft256_frame_sched
    import fft256_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int GAP        = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    input  logic             flush,
    output logic             fft_di_en,
    output logic [WIDTH-1:0] fft_di_re,
    output logic [WIDTH-1:0] fft_di_im,
    input  logic             fft_do_en,
    input  logic [WIDTH-1:0] fft_do_re,
    input  logic [WIDTH-1:0] fft_do_im,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_first,
    output logic             out_last,
    output logic [7:0]       out_frame,
    output logic             busy,
    output logic             err_frag
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [LVL_W-1:0]      FRAME_LVL = LVL_W'(FRAME_LEN);
    localparam logic [FRAME_LOG2-1:0] LAST_IDX  = frame_last_idx();
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(GAP - 1);

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic                   fifo_wr;
    logic                   fifo_rd;
    logic                   fifo_clear;
    logic [2*WIDTH-1:0]     fifo_rd_data;
    logic [LVL_W-1:0]       fifo_level;
    logic                   fifo_full;
    logic                   fifo_empty;

    sched_state_t           state;
    sched_state_t           state_nxt;
    logic [FRAME_LOG2-1:0]  rd_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   flush_pend;
    logic                   frame_ready;
    logic                   gap_done;

    // A deferred flush blocks new writes until the FIFO has been emptied,
    // so no post-flush sample can be wiped by the pending clear.
    assign in_ready = !fifo_full && !flush_pend;
    assign fifo_wr  = in_valid && in_ready;
    assign busy     = !fifo_empty || (state != ST_IDLE);

    fft_sync_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear   (fifo_clear),
        .wr_en   (fifo_wr),
        .wr_data ({in_re, in_im}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Level is the registered occupancy, so a write on this edge is not yet
    // counted; a burst therefore only starts with a whole frame on hand.
    assign frame_ready = (fifo_level >= FRAME_LVL);
    assign gap_done    = (state == ST_GAP) && (gap_cnt == GAP_LAST);

    // ------------------------------------------------------------------
    // Scheduler FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM: next state
    // A flush arriving in IDLE/GAP empties the FIFO on this edge, so the
    // stale level must not launch a burst at the same time.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (frame_ready && !flush) begin
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (rd_cnt == LAST_IDX) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_nxt = (frame_ready && !flush) ? ST_BURST : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Scheduler FSM: outputs
    // A flush during BURST is held until the last sample has been popped,
    // then the FIFO is cleared on the BURST->GAP edge.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_rd    = 1'b0;
        fifo_clear = 1'b0;
        unique case (state)
            ST_IDLE: begin
                fifo_clear = flush;
            end
            ST_BURST: begin
                fifo_rd    = 1'b1;
                fifo_clear = (rd_cnt == LAST_IDX) && (flush_pend || flush);
            end
            ST_GAP: begin
                fifo_clear = flush;
            end
            default: begin
                fifo_rd    = 1'b0;
                fifo_clear = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Burst / gap counters and deferred flush
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_cnt     <= '0;
            gap_cnt    <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (state == ST_BURST) begin
                rd_cnt <= rd_cnt + 1'b1;
            end else begin
                rd_cnt <= '0;
            end

            if ((state == ST_GAP) && !gap_done) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            if ((state == ST_BURST) && (rd_cnt != LAST_IDX)) begin
                flush_pend <= flush_pend || flush;
            end else begin
                flush_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline input register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fft_di_en <= 1'b0;
            fft_di_re <= '0;
            fft_di_im <= '0;
        end else begin
            fft_di_en <= fifo_rd;
            if (fifo_rd) begin
                fft_di_re <= fifo_rd_data[2*WIDTH-1:WIDTH];
                fft_di_im <= fifo_rd_data[WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output framer
    // frame_cnt is the number of the frame currently being received; it
    // advances after sample 255 or when a frame is cut short. out_frame is
    // its registered copy, aligned with the registered output sample.
    // ------------------------------------------------------------------
    logic [FRAME_LOG2-1:0] out_cnt;
    logic [7:0]            frame_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_cnt   <= '0;
            frame_cnt <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_frame <= '0;
            err_frag  <= 1'b0;
        end else begin
            out_valid <= fft_do_en;
            out_first <= fft_do_en && (out_cnt == '0);
            out_last  <= fft_do_en && (out_cnt == LAST_IDX);
            out_frame <= frame_cnt;
            if (fft_do_en) begin
                out_cnt <= out_cnt + 1'b1;
                if (out_cnt == LAST_IDX) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end else if (out_cnt != '0) begin
                // Enable dropped mid-frame: abandon it and resync on the
                // next enabled sample.
                err_frag  <= 1'b1;
                out_cnt   <= '0;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Sample data is passed through without reset.
    always_ff @(posedge clock) begin
        out_re <= fft_do_re;
        out_im <= fft_do_im;
    end

endmodule
